// File: rtl/message_pkg.sv
// -----------------------------------------------------------------------------
// message_pkg
// Shared definitions for the 7-segment message path: message codes understood
// by message_decoder, the sequencer FSM encoding and the layout of one queued
// display request.
// -----------------------------------------------------------------------------
package message_pkg;

    localparam logic [3:0] MSG_HELLO = 4'h0;
    localparam logic [3:0] MSG_STAGE = 4'h2;
    localparam logic [3:0] MSG_TURN  = 4'h3;
    localparam logic [3:0] MSG_SCORE = 4'h6;
    localparam logic [3:0] MSG_LOSE  = 4'h7;
    localparam logic [3:0] MSG_BLANK = 4'hF;

    localparam int ENTRY_W = 9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHOW   = 2'd1,
        ST_STICKY = 2'd2
    } seq_state_t;

    // One queued request; sticky is the MSB so the packed layout is
    // {sticky, state, level}.
    typedef struct packed {
        logic       sticky;
        logic [3:0] state;
        logic [3:0] level;
    } msg_entry_t;

endpackage

// File: rtl/msg_fifo.sv
// -----------------------------------------------------------------------------
// msg_fifo
// Small synchronous FIFO holding pending display requests.
//   clk, reset : clock, synchronous active-high reset
//   clear      : synchronous flush of all entries
//   push, din  : write request (ignored when full)
//   pop        : read request (ignored when empty)
//   full/empty : occupancy flags, derived from registered count
//   head       : oldest entry, valid whenever !empty
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module msg_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_C  = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW-1:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == FULL_C);
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        // Simultaneous push and pop leaves the count unchanged.
        if (push_ok && !pop_ok) count_d = count_q + CNT_ONE;
        if (pop_ok && !push_ok) count_d = count_q - CNT_ONE;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; only entries covered by count are ever read.
    always_ff @(posedge clk) begin
        if (push_ok && !clear) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/message_sequencer.sv
// -----------------------------------------------------------------------------
// message_sequencer
// Queues display requests from game logic and holds each one on the 7-segment
// display for at least HOLD_CYCLES cycles before showing the next.
//   clk, reset        : clock, synchronous active-high reset
//   req_valid/ready   : request handshake (ready = queue not full)
//   req_state/level   : message code and level digit
//   req_sticky        : keep message after hold expiry until replaced
//   flush             : drop queue and blank display immediately
//   state_number      : registered message code to message_decoder
//   level_number      : registered level digit to message_decoder
//   busy              : message on screen or requests pending
//   msg_done          : pulse in the final hold cycle of each message
// -----------------------------------------------------------------------------
module message_sequencer
    import message_pkg::*;
#(
    parameter int HOLD_CYCLES = 50000000,
    parameter int DEPTH       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_state,
    input  logic [3:0] req_level,
    input  logic       req_sticky,
    input  logic       flush,
    output logic [3:0] state_number,
    output logic [3:0] level_number,
    output logic       busy,
    output logic       msg_done
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;

    seq_state_t       fsm_q, fsm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       state_q, state_d;
    logic [3:0]       level_q, level_d;
    logic             sticky_q, sticky_d;

    logic             fifo_full, fifo_empty, fifo_push, fifo_pop, load;
    logic [ENTRY_W-1:0] fifo_din, fifo_head;
    msg_entry_t       head_entry;

    assign req_ready  = !fifo_full;
    assign fifo_push  = req_valid && req_ready && !flush;
    assign fifo_din   = {req_sticky, req_state, req_level};
    assign head_entry = msg_entry_t'(fifo_head);

    msg_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    always_comb begin
        fsm_d    = fsm_q;
        cnt_d    = cnt_q;
        state_d  = state_q;
        level_d  = level_q;
        sticky_d = sticky_q;
        load     = 1'b0;
        unique case (fsm_q)
            ST_IDLE: begin
                if (!fifo_empty) load = 1'b1;
            end
            ST_SHOW: begin
                if (cnt_q == '0) begin
                    // Chain straight into the next entry so there is no blank gap.
                    if (!fifo_empty) begin
                        load = 1'b1;
                    end else if (sticky_q) begin
                        fsm_d = ST_STICKY;
                    end else begin
                        fsm_d    = ST_IDLE;
                        state_d  = MSG_BLANK;
                        level_d  = '0;
                        sticky_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_STICKY: begin
                if (!fifo_empty) load = 1'b1;
            end
            default: fsm_d = ST_IDLE;
        endcase
        if (load) begin
            fsm_d    = ST_SHOW;
            cnt_d    = CNT_LOAD;
            state_d  = head_entry.state;
            level_d  = head_entry.level;
            sticky_d = head_entry.sticky;
        end
        // Flush overrides everything, including a pending pop.
        if (flush) begin
            fsm_d    = ST_IDLE;
            cnt_d    = '0;
            state_d  = MSG_BLANK;
            level_d  = '0;
            sticky_d = 1'b0;
            load     = 1'b0;
        end
    end

    assign fifo_pop = load;

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q    <= ST_IDLE;
            cnt_q    <= '0;
            state_q  <= MSG_BLANK;
            level_q  <= '0;
            sticky_q <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            level_q  <= level_d;
            sticky_q <= sticky_d;
        end
    end

    assign state_number = state_q;
    assign level_number = level_q;
    assign busy         = (fsm_q != ST_IDLE) || !fifo_empty;
    // A message aborted by flush in its final cycle does not report completion.
    assign msg_done     = (fsm_q == ST_SHOW) && (cnt_q == '0) && !flush;

endmodule

// File: tb/tb_message_sequencer.sv
// -----------------------------------------------------------------------------
// tb_message_sequencer
// Directed bench for message_sequencer with HOLD_CYCLES=4, DEPTH=4.
// Cycle 0 is the first cycle after reset release; inputs are applied and
// outputs observed shortly after each rising edge.
// -----------------------------------------------------------------------------
module tb_message_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_state;
    logic [3:0] req_level;
    logic       req_sticky;
    logic       flush;
    logic [3:0] state_number;
    logic [3:0] level_number;
    logic       busy;
    logic       msg_done;

    int checks = 0;
    int errors = 0;

    logic [3:0] codes [6] = '{4'h0, 4'h2, 4'h3, 4'h6, 4'h7, 4'h1};

    message_sequencer #(
        .HOLD_CYCLES (4),
        .DEPTH       (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_state    (req_state),
        .req_level    (req_level),
        .req_sticky   (req_sticky),
        .flush        (flush),
        .state_number (state_number),
        .level_number (level_number),
        .busy         (busy),
        .msg_done     (msg_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [3:0] s, input logic [3:0] l, input logic st);
        req_valid  = 1'b1;
        req_state  = s;
        req_level  = l;
        req_sticky = st;
    endtask

    task automatic idle_inputs();
        req_valid  = 1'b0;
        req_state  = 4'h0;
        req_level  = 4'h0;
        req_sticky = 1'b0;
        flush      = 1'b0;
    endtask

    // Hold reset for three edges, checking the reset state after each one,
    // then release so that the current cycle becomes cycle 0.
    task automatic do_reset(input int t);
        idle_inputs();
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("t%0d rst%0d state", t, i), 32'(state_number), 32'hF);
            chk($sformatf("t%0d rst%0d level", t, i), 32'(level_number), 32'h0);
            chk($sformatf("t%0d rst%0d busy", t, i), 32'(busy), 32'h0);
            chk($sformatf("t%0d rst%0d ready", t, i), 32'(req_ready), 32'h1);
            chk($sformatf("t%0d rst%0d done", t, i), 32'(msg_done), 32'h0);
        end
        reset = 1'b0;
    endtask

    task automatic run(input int t, input int n);
        int done_cnt;
        done_cnt = 0;
        for (int c = 0; c < n; c++) begin
            logic [3:0] es, el;
            logic       ed, eb, er;
            int         idx;
            idle_inputs();
            es = 4'hF; el = 4'h0; ed = 1'b0; eb = 1'b0; er = 1'b1;
            case (t)
                2: begin
                    if (c == 0) push(4'h2, 4'h3, 1'b0);
                    if (c >= 2 && c <= 5) begin es = 4'h2; el = 4'h3; end
                    ed = (c == 5);
                    eb = (c >= 1 && c <= 5);
                end
                3: begin
                    if (c <= 5) push(codes[c], 4'(c + 1), 1'b0);
                    if (c >= 2 && c <= 21) begin
                        idx = (c - 2) / 4;
                        es  = codes[idx];
                        el  = 4'(idx + 1);
                    end
                    ed = (c >= 5 && c <= 21 && ((c - 5) % 4) == 0);
                    eb = (c >= 1 && c <= 21);
                    er = (c != 5);
                end
                4: begin
                    if (c == 0)  push(4'h7, 4'h0, 1'b1);
                    if (c == 20) push(4'h0, 4'h0, 1'b0);
                    if (c >= 2 && c <= 21) es = 4'h7;
                    if (c >= 22 && c <= 25) es = 4'h0;
                    ed = (c == 5 || c == 25);
                    eb = (c >= 1 && c <= 25);
                end
                5: begin
                    if (c == 0) push(4'h2, 4'h9, 1'b0);
                    if (c == 1) push(4'h3, 4'h1, 1'b0);
                    if (c == 2) push(4'h6, 4'h2, 1'b0);
                    if (c == 4) begin
                        push(4'h7, 4'h4, 1'b0);
                        flush = 1'b1;
                    end
                    if (c >= 2 && c <= 4) begin es = 4'h2; el = 4'h9; end
                    eb = (c >= 1 && c <= 4);
                end
                6: begin
                    if (c == 0) push(4'h3, 4'h0, 1'b0);
                    if (c == 5) push(4'h6, 4'h0, 1'b0);
                    if (c >= 2 && c <= 5)  es = 4'h3;
                    if (c >= 7 && c <= 10) es = 4'h6;
                    ed = (c == 5 || c == 10);
                    eb = (c >= 1 && c <= 10);
                end
                default: ;
            endcase
            #1;
            chk($sformatf("t%0d c%0d state", t, c), 32'(state_number), 32'(es));
            chk($sformatf("t%0d c%0d level", t, c), 32'(level_number), 32'(el));
            chk($sformatf("t%0d c%0d done", t, c), 32'(msg_done), 32'(ed));
            chk($sformatf("t%0d c%0d busy", t, c), 32'(busy), 32'(eb));
            chk($sformatf("t%0d c%0d ready", t, c), 32'(req_ready), 32'(er));
            if (msg_done === 1'b1) done_cnt++;
            @(posedge clk); #1;
        end
        idle_inputs();
        case (t)
            2:       chk("t2 done_count", 32'(done_cnt), 32'd1);
            3:       chk("t3 done_count", 32'(done_cnt), 32'd5);
            4:       chk("t4 done_count", 32'(done_cnt), 32'd2);
            5:       chk("t5 done_count", 32'(done_cnt), 32'd0);
            default: chk("t6 done_count", 32'(done_cnt), 32'd2);
        endcase
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        do_reset(2); run(2, 9);
        do_reset(3); run(3, 25);
        do_reset(4); run(4, 28);
        do_reset(5); run(5, 13);
        do_reset(6); run(6, 13);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/message_sequencer.md
Name: message_sequencer

Overview:
Producer side of the 7-segment message path. Game logic posts display requests, each a message code plus level digit. The block queues them in a small FIFO and holds each on the display for a guaranteed minimum time. It drives the state_number/level_number inputs of message_decoder, so requests never overwrite a message before the player can read it.

Parameters:
HOLD_CYCLES, 50000000, minimum cycles each message stays on screen (1 s at 50 MHz); legal range >= 1.
DEPTH, 4, request FIFO entries; power of two, >= 2.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
req_valid  input  1  request strobe; pushed on the clk edge when req_valid && req_ready && !flush
req_ready  output  1  FIFO not full (combinational from occupancy)
req_state  input  4  message code for message_decoder
req_level  input  4  level digit; stored for every code, only shown for the STAGE code
req_sticky  input  1  1 = message stays after hold expiry until the next request is shown
flush  input  1  drop all queued requests and blank the display
state_number  output  4  registered; to message_decoder state_number
level_number  output  4  registered; to message_decoder level_number
busy  output  1  (fsm != IDLE) || FIFO non-empty
msg_done  output  1  one-cycle pulse in the last hold cycle of every displayed message

Behaviour:
- Reset and flush: FSM=IDLE, FIFO empty, hold counter=0, state_number=4'hF (MSG_BLANK), level_number=0, busy=0, msg_done=0, req_ready=1.
- flush priority: flush > reset-free normal operation; a req_valid in the same cycle is dropped; no msg_done for the aborted message.
- FIFO entry = {sticky, state, level}, 9 bits.
- Push and pop in the same cycle leave occupancy unchanged.
- Push when full is ignored; the bench must never see overflow corruption.
- There is no bypass path.
- FSM states: IDLE, SHOW, STICKY.
  - IDLE: outputs blank. If the FIFO is non-empty, pop the head, register state/level/sticky, set counter=HOLD_CYCLES-1, and go to SHOW.
  - SHOW: counter decrements each cycle. msg_done = (fsm==SHOW && counter==0). At counter==0:
    - FIFO non-empty: pop the next entry, load it, reload the counter, stay in SHOW. This gives back-to-back messages with no blank gap.
    - FIFO empty, current sticky=1: go to STICKY, outputs retained.
    - FIFO empty, current sticky=0: go to IDLE, outputs blank next cycle.
  - STICKY: outputs held. If the FIFO is non-empty, pop, load, and go to SHOW.
- Latency: a request pushed on edge t is visible on the outputs after edge t+1, when starting from IDLE or STICKY.
- Each message is visible exactly HOLD_CYCLES cycles unless it is sticky or flushed.
- Simultaneous push and expiry with the FIFO empty: the pushed entry is not yet poppable. A non-sticky message therefore blanks for exactly 1 cycle (IDLE) before the new message.
- Unknown codes are passed through unchanged; the decoder blanks them.
- Counter width: $clog2(HOLD_CYCLES+1). With HOLD_CYCLES=1, msg_done is asserted in every SHOW cycle.

Decomposition:
- Shared package message_pkg holds:
  - message codes MSG_HELLO=4'h0, MSG_STAGE=4'h2, MSG_TURN=4'h3, MSG_SCORE=4'h6, MSG_LOSE=4'h7, MSG_BLANK=4'hF;
  - FSM state encoding (IDLE/SHOW/STICKY);
  - FIFO entry width constant (9).
- One sub-module, msg_fifo: synchronous FIFO with parameters DEPTH and WIDTH, push/pop/full/empty/head outputs, and synchronous reset plus clear.

Test Plan (HOLD_CYCLES=4, DEPTH=4, cycle 0 = first cycle after reset release):
1. Reset held 3 cycles -> state_number=F, level_number=0, busy=0, req_ready=1, msg_done=0 throughout.
2. Push {state=2, level=3, sticky=0} in cycle 0 -> outputs 2/3 in cycles 2-5, msg_done high only in cycle 5, outputs F/0 from cycle 6, busy low from cycle 6.
3. Push codes 0,2,3,6,7,1 (non-sticky) in cycles 0-5:
   - first five accepted; req_ready=0 in cycle 5; code 1 dropped;
   - display order 0,2,3,6,7, each 4 cycles contiguous from cycle 2;
   - five msg_done pulses (cycles 5, 9, 13, 17, 21); blank from cycle 22.
4. Push {7,0,sticky=1} in cycle 0 -> outputs 7 from cycle 2 onward, one msg_done in cycle 5, still 7 in cycle 19. Push {0,0,0} in cycle 20 -> outputs 0 from cycle 22.
5. Push three non-sticky requests in cycles 0-2, assert flush in cycle 4 -> outputs F from cycle 5, busy=0, req_ready=1, no msg_done in cycles 4-12.
6. Push {3,0,0} in cycle 0, push {6,0,0} in cycle 5 (expiry cycle, FIFO empty) -> F in cycle 6, 6 shown cycles 7-10.
